// File: rtl/dircc_types_pkg.sv
// Shared packet types for the DIRCC Avalon-ST packet I/O block.
package dircc_types_pkg;

  localparam int PACKET_BITS = 224;

  typedef struct packed {
    logic [31:0] hw_addr;
    logic [15:0] sw_addr;
    logic [7:0]  port;
    logic [7:0]  flag;
  } address_t;

  typedef logic [63:0] packet_data_t;

  typedef struct packed {
    address_t     dest_addr;
    address_t     src_addr;
    logic [31:0]  lamport;
    packet_data_t data;
  } packet_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  // Number of beats needed to carry one packet on a bus of the given width.
  function automatic int beats_for(input int data_width);
    return (PACKET_BITS + data_width - 1) / data_width;
  endfunction

endpackage

// File: rtl/dircc_st_rx.sv
// Avalon-ST sink: reassembles beats into a packet_t, beat 0 holding the MSBs.
module dircc_st_rx
  import dircc_types_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  booting,
  output packet_t               rx_packet,
  output logic                  rx_packet_valid,
  output logic                  receive_nearly_done,
  output logic                  receive_done
);

  localparam int BEATS = beats_for(DATA_WIDTH);
  localparam int PW    = BEATS * DATA_WIDTH;
  localparam int PAD   = PW - PACKET_BITS;
  // Counter saturates at BEATS+1 so over-long packets stay distinguishable.
  localparam int CW    = $clog2(BEATS + 2);

  logic [PW-1:0] asm_q, asm_nxt, asm_shift;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          active_q, active_nxt;
  logic          accept, eop_hit;

  assign in_ready  = !booting;
  assign accept    = in_valid && in_ready;
  assign asm_shift = asm_nxt >> PAD;
  assign receive_nearly_done = eop_hit && reset_n;

  // Next assembly state from the beat being accepted this cycle.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
    asm_nxt    = asm_q;
    cnt_nxt    = cnt_q;
    active_nxt = active_q;
    eop_hit    = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        asm_nxt = '0;
        asm_nxt[PW-1 -: DATA_WIDTH] = in_data;
        cnt_nxt    = CW'(1);
        active_nxt = 1'b1;
      end else if (active_q) begin
        if (cnt_q < CW'(BEATS))
          asm_nxt[(BEATS - 1 - int'(cnt_q)) * DATA_WIDTH +: DATA_WIDTH] = in_data;
        if (cnt_q <= CW'(BEATS))
          cnt_nxt = cnt_q + 1'b1;
      end
      if (in_endofpacket && (in_startofpacket || active_q)) begin
        eop_hit    = 1'b1;
        active_nxt = 1'b0;
      end
    end
  end

  // Assembly registers and the registered packet/done outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the assembly buffer is reset too, so a packet cut short by reset never leaks old words.
      asm_q           <= '0;
      cnt_q           <= '0;
      active_q        <= 1'b0;
      rx_packet       <= '0;
      rx_packet_valid <= 1'b0;
      receive_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      asm_q        <= asm_nxt;
      cnt_q        <= cnt_nxt;
      active_q     <= active_nxt;
      receive_done <= eop_hit;
      if (accept && in_startofpacket)
        rx_packet_valid <= 1'b0;
      // Later assignment wins for a single-beat sop+eop packet.
      if (eop_hit) begin
        rx_packet       <= asm_shift[PACKET_BITS-1:0];
        rx_packet_valid <= (cnt_nxt == CW'(BEATS));
      end
    end
  end

endmodule

// File: rtl/dircc_st_tx.sv
// Avalon-ST source: serialises a captured packet_t, MSB beat first.
module dircc_st_tx
  import dircc_types_pkg::*;
#(
  parameter int BITS_PER_SYMBOL = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int EMPTY_WIDTH     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   write_packet,
  input  packet_t                tx_packet,
  output logic                   sending,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int BEATS    = beats_for(DATA_WIDTH);
  localparam int PW       = BEATS * DATA_WIDTH;
  localparam int PAD      = PW - PACKET_BITS;
  localparam int PAD_SYMS = PAD / BITS_PER_SYMBOL;
  localparam int IW       = (BEATS > 1) ? $clog2(BEATS) : 1;

  tx_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] sbuf_q, sbuf_d, tx_padded;

  // Packet left-justified so padding ends up in the last beat's low symbols.
  assign tx_padded = PW'(tx_packet) << PAD;

  assign out_valid         = (state_q == TX_SEND);
  assign sending           = out_valid;
  assign out_startofpacket = out_valid && (idx_q == '0);
  assign out_endofpacket   = out_valid && (idx_q == IW'(BEATS - 1));
  assign out_data          = out_valid ? sbuf_q[(BEATS - 1 - int'(idx_q)) * DATA_WIDTH +: DATA_WIDTH]
                                       : '0;
  assign out_empty         = out_endofpacket ? EMPTY_WIDTH'(PAD_SYMS) : '0;

  // Next state: capture when idle, advance on accepted beats, drop out after the eop beat.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sbuf_d  = sbuf_q;
    case (state_q)
      TX_IDLE: begin
        if (write_packet) begin
          sbuf_d  = tx_padded;
          idx_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (out_ready) begin
          if (idx_q == IW'(BEATS - 1)) begin
            idx_d   = '0;
            state_d = TX_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
      idx_q   <= '0;
      sbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sbuf_q  <= sbuf_d;
    end
  end

endmodule

// File: rtl/dircc_avalon_st_packet_io.sv
// Top: independent Avalon-ST receive and transmit paths for DIRCC packets.
module dircc_avalon_st_packet_io
  import dircc_types_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 4,
  localparam int DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int EMPTY_WIDTH     = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   booting,
  output packet_t                rx_packet,
  output logic                   rx_packet_valid,
  output logic                   receive_nearly_done,
  output logic                   receive_done,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   write_packet,
  input  packet_t                tx_packet,
  output logic                   sending
);

  // Receive side reconstructs length from beat count, so in_empty carries no information.
  logic unused_in_empty;
  assign unused_in_empty = ^in_empty;

  dircc_st_rx #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_data             (in_data),
    .in_startofpacket    (in_startofpacket),
    .in_endofpacket      (in_endofpacket),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .booting             (booting),
    .rx_packet           (rx_packet),
    .rx_packet_valid     (rx_packet_valid),
    .receive_nearly_done (receive_nearly_done),
    .receive_done        (receive_done)
  );

  dircc_st_tx #(
    .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
    .DATA_WIDTH      (DATA_WIDTH),
    .EMPTY_WIDTH     (EMPTY_WIDTH)
  ) u_tx (
    .clk               (clk),
    .reset_n           (reset_n),
    .write_packet      (write_packet),
    .tx_packet         (tx_packet),
    .sending           (sending),
    .out_data          (out_data),
    .out_empty         (out_empty),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_valid         (out_valid),
    .out_ready         (out_ready)
  );

endmodule

// File: tb/tb_dircc_avalon_st_packet_io.sv
// Scoreboard bench for dircc_avalon_st_packet_io at default parameters (7 x 32-bit beats).
module tb_dircc_avalon_st_packet_io;
  import dircc_types_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic [1:0]  in_empty;
  logic        in_startofpacket, in_endofpacket, in_valid, in_ready;
  logic        booting;
  packet_t     rx_packet;
  logic        rx_packet_valid, receive_nearly_done, receive_done;
  logic [31:0] out_data;
  logic [1:0]  out_empty;
  logic        out_startofpacket, out_endofpacket, out_valid, out_ready;
  logic        write_packet;
  packet_t     tx_packet;
  logic        sending;

  // Bench-side drivers; loopback routes the source straight into the sink.
  logic        loopback;
  logic [31:0] drv_data;
  logic        drv_sop, drv_eop, drv_valid, drv_out_ready;

  assign in_data          = loopback ? out_data          : drv_data;
  assign in_empty         = loopback ? out_empty         : 2'd0;
  assign in_startofpacket = loopback ? out_startofpacket : drv_sop;
  assign in_endofpacket   = loopback ? out_endofpacket   : drv_eop;
  assign in_valid         = loopback ? out_valid         : drv_valid;
  assign out_ready        = loopback ? in_ready          : drv_out_ready;

  dircc_avalon_st_packet_io dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_data             (in_data),
    .in_empty            (in_empty),
    .in_startofpacket    (in_startofpacket),
    .in_endofpacket      (in_endofpacket),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .booting             (booting),
    .rx_packet           (rx_packet),
    .rx_packet_valid     (rx_packet_valid),
    .receive_nearly_done (receive_nearly_done),
    .receive_done        (receive_done),
    .out_data            (out_data),
    .out_empty           (out_empty),
    .out_startofpacket   (out_startofpacket),
    .out_endofpacket     (out_endofpacket),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .write_packet        (write_packet),
    .tx_packet           (tx_packet),
    .sending             (sending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [223:0] pkt;
    logic         valid;
  } rx_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } tx_exp_t;

  rx_exp_t rx_q[$];
  tx_exp_t tx_q[$];
  rx_exp_t rx_e;
  tx_exp_t tx_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Word i of a packet, counting from the MSB end.
  function automatic logic [31:0] beat_of(input logic [223:0] p, input int i);
    logic [223:0] s;
    s = p >> (32 * (6 - i));
    return s[31:0];
  endfunction

  function automatic logic [223:0] rand_pkt();
    logic [223:0] p;
    for (int i = 0; i < 7; i++) p = {p[191:0], 32'($urandom)};
    return p;
  endfunction

  function automatic void push_tx(input logic [223:0] p);
    tx_exp_t t;
    for (int i = 0; i < 7; i++) begin
      t.data = beat_of(p, i); t.sop = (i == 0); t.eop = (i == 6); t.empty = 2'd0;
      tx_q.push_back(t);
    end
  endfunction

  function automatic void push_rx(input logic [223:0] p, input logic v);
    rx_exp_t r;
    r.pkt = p; r.valid = v;
    rx_q.push_back(r);
  endfunction

  // Scoreboard: pop expected items whenever the DUT presents a result.
  always @(negedge clk) begin
    if (receive_done) begin
      n_checks++;
      if (rx_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: receive_done=1 got pkt=%h valid=%b, required no packet", rx_packet, rx_packet_valid);
      end else begin
        rx_e = rx_q.pop_front();
        if (rx_packet !== rx_e.pkt || rx_packet_valid !== rx_e.valid) begin
          n_fail++;
          $display("FAIL rx_packet: got pkt=%h valid=%b, required pkt=%h valid=%b",
                   rx_packet, rx_packet_valid, rx_e.pkt, rx_e.valid);
        end
      end
    end
    if (out_valid && out_ready) begin
      n_checks++;
      if (tx_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: beat data=%h, required no beat", out_data);
      end else begin
        tx_e = tx_q.pop_front();
        if (out_data !== tx_e.data || out_startofpacket !== tx_e.sop ||
            out_endofpacket !== tx_e.eop || out_empty !== tx_e.empty) begin
          n_fail++;
          $display("FAIL tx_beat: got %h sop=%b eop=%b empty=%0d, required %h sop=%b eop=%b empty=%0d",
                   out_data, out_startofpacket, out_endofpacket, out_empty,
                   tx_e.data, tx_e.sop, tx_e.eop, tx_e.empty);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive n sink beats; beats past 7 carry random filler.
  task automatic rx_drive(input logic [223:0] p, input int n, input bit with_sop,
                          input bit with_eop, input bit exp_nd);
    for (int i = 0; i < n; i++) begin
      drv_valid = 1'b1;
      drv_data  = (i < 7) ? beat_of(p, i) : 32'($urandom);
      drv_sop   = with_sop && (i == 0);
      drv_eop   = with_eop && (i == n - 1);
      @(negedge clk);
      if (drv_eop) begin
        n_checks++;
        if (receive_nearly_done !== exp_nd) begin
          n_fail++;
          $display("FAIL nearly_done: got %b, required %b", receive_nearly_done, exp_nd);
        end
      end
      step();
    end
    drv_valid = 1'b0; drv_sop = 1'b0; drv_eop = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && (rx_q.size() != 0 || tx_q.size() != 0); i++) step();
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (rx_q.size() != 0 || tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: pending rx=%0d tx=%0d, required 0 0", name, rx_q.size(), tx_q.size());
    end
    step();
  endtask

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    n_checks++;
    if (rx_packet !== '0 || rx_packet_valid !== 1'b0 || receive_done !== 1'b0 ||
        receive_nearly_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_rx: got pkt=%h valid=%b done=%b nd=%b, required all zero",
               name, rx_packet, rx_packet_valid, receive_done, receive_nearly_done);
    end
    n_checks++;
    if (sending !== 1'b0 || out_valid !== 1'b0 || out_startofpacket !== 1'b0 ||
        out_endofpacket !== 1'b0 || out_data !== 32'd0 || out_empty !== 2'd0) begin
      n_fail++;
      $display("FAIL %s_tx: got sending=%b valid=%b sop=%b eop=%b data=%h empty=%0d, required all zero",
               name, sending, out_valid, out_startofpacket, out_endofpacket, out_data, out_empty);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_rx_basic();
    packet_t p;
    p = rand_pkt();
    p.lamport = 32'h0000_0005;
    push_rx(p, 1'b1);
    rx_drive(p, 7, 1, 1, 1);
    @(negedge clk);
    n_checks++;
    if (receive_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_done_latency: got %b, required 1", receive_done);
    end
    @(negedge clk);
    n_checks++;
    if (receive_done !== 1'b0 || rx_packet_valid !== 1'b1 || rx_packet.lamport !== 32'h5) begin
      n_fail++;
      $display("FAIL rx_done_pulse: got done=%b valid=%b lamport=%h, required 0 1 00000005",
               receive_done, rx_packet_valid, rx_packet.lamport);
    end
    step();
    wait_drain("rx_basic");
  endtask

  task automatic test_booting();
    logic [223:0] p;
    p = rand_pkt();
    booting = 1'b1;
    drv_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL booting_ready: got %b, required 0", in_ready);
    end
    step();
    rx_drive(p, 7, 1, 1, 0);
    repeat (3) step();
    booting = 1'b0;
    push_rx(p, 1'b1);
    rx_drive(p, 7, 1, 1, 1);
    wait_drain("booting");
  endtask

  task automatic test_malformed();
    logic [223:0] p;
    // Short packet: only the top four words survive.
    p = rand_pkt();
    push_rx(p & ({224{1'b1}} << 96), 1'b0);
    rx_drive(p, 4, 1, 1, 1);
    wait_drain("short");
    // Long packet: first seven words kept, flagged malformed.
    p = rand_pkt();
    push_rx(p, 1'b0);
    rx_drive(p, 9, 1, 1, 1);
    wait_drain("long");
    // Stray eop beat with no packet in progress is dropped.
    rx_drive(rand_pkt(), 1, 0, 1, 0);
    // Sop mid-packet restarts assembly.
    rx_drive(rand_pkt(), 3, 1, 0, 0);
    p = rand_pkt();
    push_rx(p, 1'b1);
    rx_drive(p, 7, 1, 1, 1);
    wait_drain("restart");
  endtask

  task automatic test_tx_stall();
    logic [223:0] p;
    logic [31:0]  held;
    logic         stalled, eop_acc, done;
    p = rand_pkt();
    push_tx(p);
    p[223:192] = 32'h1;
    tx_q[0].data = 32'h1;
    drv_out_ready = 1'b0;
    tx_packet = p; write_packet = 1'b1;
    step();
    write_packet = 1'b0;
    tx_packet = rand_pkt();
    @(negedge clk);
    n_checks++;
    if (sending !== 1'b1 || out_valid !== 1'b1 || out_startofpacket !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_start: got sending=%b valid=%b sop=%b, required 1 1 1",
               sending, out_valid, out_startofpacket);
    end
    step();
    stalled = 1'b0; eop_acc = 1'b0; done = 1'b0; held = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      drv_out_ready = (c % 2 == 0);
      @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (out_data !== held) begin
          n_fail++;
          $display("FAIL tx_hold: got %h, required %h", out_data, held);
        end
      end
      if (eop_acc) begin
        done = 1'b1;
        n_checks++;
        if (sending !== 1'b0) begin
          n_fail++;
          $display("FAIL tx_end: sending got %b, required 0", sending);
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      eop_acc = out_valid && out_ready && out_endofpacket;
      step();
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL tx_timeout: eop accepted=%b, required 1", done);
    end
    drv_out_ready = 1'b0;
    wait_drain("tx_stall");
  endtask

  task automatic test_loopback();
    logic [223:0] p;
    p = rand_pkt();
    push_tx(p);
    push_rx(p, 1'b1);
    loopback = 1'b1;
    tx_packet = p; write_packet = 1'b1;
    step();
    for (int c = 0; c < 30; c++) begin
      tx_packet    = rand_pkt();
      write_packet = (c == 2) || out_endofpacket;
      @(negedge clk);
      if (!out_valid) break;
      step();
    end
    write_packet = 1'b0;
    repeat (4) step();
    @(negedge clk);
    n_checks++;
    if (sending !== 1'b0) begin
      n_fail++;
      $display("FAIL loopback_ignore: sending got %b, required 0", sending);
    end
    step();
    loopback = 1'b0;
    wait_drain("loopback");
  endtask

  task automatic test_reset_mid();
    logic [223:0] p_tx, p_rx;
    p_tx = rand_pkt(); p_rx = rand_pkt();
    push_tx(p_tx);
    drv_out_ready = 1'b1;
    tx_packet = p_tx; write_packet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_valid = 1'b1; drv_data = beat_of(p_rx, i); drv_sop = (i == 0); drv_eop = 1'b0;
      step();
      write_packet = 1'b0;
    end
    reset_n = 1'b0; drv_valid = 1'b0; drv_sop = 1'b0;
    @(negedge clk);
    step();
    tx_q.delete();
    check_idle_outputs("reset_mid");
    step();
    reset_n = 1'b1;
    drv_out_ready = 1'b0;
    step();
    // Tail of the abandoned packet must be ignored.
    for (int i = 3; i < 7; i++) begin
      drv_valid = 1'b1; drv_data = beat_of(p_rx, i); drv_eop = (i == 6);
      step();
    end
    drv_valid = 1'b0; drv_eop = 1'b0;
    p_rx = rand_pkt();
    push_rx(p_rx, 1'b1);
    rx_drive(p_rx, 7, 1, 1, 1);
    wait_drain("reset_mid");
  endtask

  initial begin
    reset_n = 1'b0; booting = 1'b0; loopback = 1'b0;
    drv_data = '0; drv_sop = 1'b0; drv_eop = 1'b0; drv_valid = 1'b0; drv_out_ready = 1'b0;
    write_packet = 1'b0; tx_packet = '0;
    test_reset();
    test_rx_basic();
    test_booting();
    test_malformed();
    test_tx_stall();
    test_loopback();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
